main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 1: 1 = memory states hold until mem_ready=1; 0 = mem_ready ignored, every memory access completes in one cycle.
REQ-002 Parameter EN_LUI, default 1: 1 = lui (0110111) decoded and executed; 0 = lui treated as illegal.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
REQ-006 op  in  7  opcode field of the instruction register.
REQ-007 zero  in  1  ALU zero flag, for branch resolution.
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each  datapath selects.
REQ-011 ImmSrc  out  3  immediate format: I=000, S=001, B=010, J=011, U=100.
REQ-012 illegal  out  1  sticky trap flag; instret  out  CNT_W  retired-instruction count.

Function
REQ-013 Encodings: ALUSrcA 00=PC, 01=OldPC, 10=rd1, 11=zero; ALUSrcB 00=rd2, 01=ImmExt, 10=const 4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult; AdrSrc 0=PC, 1=Result.
REQ-014 Registered states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, TRAP; every output is a combinational function of state, op, zero and mem_ready only.
REQ-015 Outputs not listed for a state are 0.
REQ-016 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCWrite=go; transition to DECODE on go, else stay; go=mem_ready if MEM_WAIT=1, else 1.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by op: lw/sw->MEMADR, R-type->EXECR, I-ALU->EXECI, beq->BEQ, jal->JAL, lui->LUI (if EN_LUI), any other->TRAP.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op=lw, MEMWRITE if op=sw.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; transition to MEMWB on go, else stay.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-021 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, asserted for every cycle spent in the state; transition to FETCH on go, else stay.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both go to ALUWB next.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-024 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero; next FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-026 LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00; next ALUWB.
REQ-027 TRAP: illegal=1, all enables 0; the state is absorbing until reset.
REQ-028 ImmSrc is decoded from op in every state: lw/I-ALU->000, sw->001, beq->010, jal->011, lui->100, other->000.
REQ-029 instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (on go), ALUWB or BEQ; it wraps modulo 2^CNT_W; a TRAP entry does not count.
REQ-030 Instruction latency with MEM_WAIT=0: lw=5, sw=4, R/I/lui/jal=4, beq=3 cycles; each memory wait cycle adds 1.

Reset
REQ-031 When reset_n=0: state=FETCH, instret=0, illegal=0, immediately, independent of clk.
REQ-032 Reset asserted mid-instruction (including in TRAP or during a memory wait) aborts the instruction with no further RegWrite/MemWrite/PCWrite.
REQ-033 After reset_n rises, the first active edge evaluates FETCH.

Verification
REQ-034 MEM_WAIT=0, op=0000011 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instret 0->1.
REQ-035 MEM_WAIT=1, op=0100011, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH; instret +1.
REQ-036 op=1100011 with zero=1, then zero=0 -> PCWrite=1 in BEQ only for the first; both retire.
REQ-037 op=1111111 -> TRAP after DECODE, illegal=1 held for 20 cycles, all enables 0, instret unchanged.
REQ-038 EN_LUI=0, op=0110111 -> TRAP; EN_LUI=1 -> LUI with ALUSrcA=11, ImmSrc=100, then ALUWB.
REQ-039 CNT_W=4: retire 17 R-type instructions -> instret=1; assert reset_n=0 in EXECR -> instret=0 and state=FETCH before the next edge.

Source files
------------

// File: rtl/main_fsm.sv
// ---------------------------------------------------------------------------
// main_fsm -- multicycle RISC-V control unit.
//
// Sequences FETCH / DECODE / execute / writeback for lw, sw, R-type, I-ALU,
// beq, jal and (optionally) lui. Any other opcode parks the machine in an
// absorbing TRAP state that raises 'illegal' until reset. It also counts
// retired instructions.
//
// Parameters
//   MEM_WAIT  1: FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0: single cycle
//   EN_LUI    1: lui executed; 0: lui traps
//   CNT_W     width of the retired-instruction counter
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   op         opcode field of the instruction register
//   zero       ALU zero flag (branch resolution)
//   mem_ready  memory access completes this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite     datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp               datapath selects (2 bit)
//   ImmSrc     immediate format I=000 S=001 B=010 J=011 U=100
//   illegal    high while the machine sits in TRAP
//   instret    retired-instruction count, wraps modulo 2^CNT_W
//
// All datapath controls are combinational functions of the current state,
// op, zero and mem_ready; only the state and the counter are registered.
// ---------------------------------------------------------------------------
module main_fsm #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned EN_LUI   = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  // State encoding
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  // Opcodes
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // Mux select encodings
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RD1   = 2'b10;
  localparam logic [1:0] SA_ZERO  = 2'b11;
  localparam logic [1:0] SB_RD2   = 2'b00;
  localparam logic [1:0] SB_IMM   = 2'b01;
  localparam logic [1:0] SB_FOUR  = 2'b10;
  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_DATA   = 2'b01;
  localparam logic [1:0] RS_ALURES = 2'b10;
  localparam logic [1:0] AOP_ADD  = 2'b00;
  localparam logic [1:0] AOP_SUB  = 2'b01;
  localparam logic [1:0] AOP_FUNC = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             go_c;
  logic             retire_c;

  // Memory handshake: without wait support every access completes at once.
  assign go_c = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;

  // Immediate format depends on the opcode alone, in every state.
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Next state and control outputs
  always_comb begin
    state_d   = state_q;
    retire_c  = 1'b0;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RS_ALUOUT;
    ALUSrcA   = SA_PC;
    ALUSrcB   = SB_RD2;
    ALUOp     = AOP_ADD;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed and routed straight from the ALU into PC.
        AdrSrc    = 1'b0;
        ALUSrcA   = SA_PC;
        ALUSrcB   = SB_FOUR;
        ALUOp     = AOP_ADD;
        ResultSrc = RS_ALURES;
        IRWrite   = go_c;
        PCWrite   = go_c;
        if (go_c) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Pre-compute the branch/jump target OldPC + imm.
        ALUSrcA = SA_OLDPC;
        ALUSrcB = SB_IMM;
        ALUOp   = AOP_ADD;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = (EN_LUI != 0) ? S_LUI : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = SA_RD1;
        ALUSrcB = SB_IMM;
        ALUOp   = AOP_ADD;
        // op is expected stable from DECODE; anything else is unrecoverable.
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_TRAP;
      end

      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RS_ALUOUT;
        if (go_c) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        ResultSrc = RS_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
        retire_c  = 1'b1;
      end

      S_MEMWRITE: begin
        // Write strobe stays up for the whole wait so memory can latch it late.
        AdrSrc    = 1'b1;
        ResultSrc = RS_ALUOUT;
        MemWrite  = 1'b1;
        if (go_c) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end

      S_EXECR: begin
        ALUSrcA = SA_RD1;
        ALUSrcB = SB_RD2;
        ALUOp   = AOP_FUNC;
        state_d = S_ALUWB;
      end

      S_EXECI: begin
        ALUSrcA = SA_RD1;
        ALUSrcB = SB_IMM;
        ALUOp   = AOP_FUNC;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc = RS_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
        retire_c  = 1'b1;
      end

      S_BEQ: begin
        // Target sits in ALUOut from DECODE while the ALU compares rd1/rd2.
        ALUSrcA   = SA_RD1;
        ALUSrcB   = SB_RD2;
        ALUOp     = AOP_SUB;
        ResultSrc = RS_ALUOUT;
        PCWrite   = zero;
        state_d   = S_FETCH;
        retire_c  = 1'b1;
      end

      S_JAL: begin
        // PC <- target (ALUOut) while the ALU forms the link OldPC + 4.
        ALUSrcA   = SA_OLDPC;
        ALUSrcB   = SB_FOUR;
        ALUOp     = AOP_ADD;
        ResultSrc = RS_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end

      S_LUI: begin
        // 0 + U-immediate
        ALUSrcA = SA_ZERO;
        ALUSrcB = SB_IMM;
        ALUOp   = AOP_ADD;
        state_d = S_ALUWB;
      end

      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end

      default: begin
        // Unreachable encodings fall into the trap.
        state_d = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_fsm -- self-checking bench for main_fsm.
// Two instances: dut_w (MEM_WAIT=1, EN_LUI=1, CNT_W=32) and
// dut_n (MEM_WAIT=0, EN_LUI=0, CNT_W=4). The idle one is held in reset.
// Expected behaviour comes from per-instruction step lists built from the
// opcode, each step mapped to its control-signal table row.
// ---------------------------------------------------------------------------
module tb_main_fsm;

  // Instruction steps
  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4,
                 PH_MWR = 5, PH_ER = 6, PH_EI = 7, PH_AW = 8, PH_B = 9,
                 PH_J = 10, PH_L = 11, PH_T = 12;
  // Instruction classes
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4,
                 C_JAL = 5, C_LUI = 6, C_TRAP = 7;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111,
                         LUI = 7'b0110111;
  // PCWrite/IRWrite are not judged while reset is held.
  localparam logic [16:0] RST_MASK = 17'b0_1101_1111_1111_1111;

  logic clk;
  logic rstn_w, rstn_n;
  logic [6:0] op_w, op_n;
  logic zero_w, zero_n, mr_w, mr_n;

  logic pcw_w, adr_w, memw_w, irw_w, regw_w, ill_w;
  logic [1:0] rs_w, sa_w, sb_w, aop_w;
  logic [2:0] imm_w;
  logic [31:0] cnt_w;
  logic pcw_n, adr_n, memw_n, irw_n, regw_n, ill_n;
  logic [1:0] rs_n, sa_n, sb_n, aop_n;
  logic [2:0] imm_n;
  logic [3:0] cnt_n;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cnt_m_w = 0;
  int unsigned cnt_m_n = 0;

  wire [16:0] obs_w = {pcw_w, adr_w, memw_w, irw_w, regw_w, rs_w, sa_w, sb_w, aop_w, imm_w, ill_w};
  wire [16:0] obs_n = {pcw_n, adr_n, memw_n, irw_n, regw_n, rs_n, sa_n, sb_n, aop_n, imm_n, ill_n};

  main_fsm #(.MEM_WAIT(1), .EN_LUI(1), .CNT_W(32)) dut_w (
    .clk(clk), .reset_n(rstn_w), .op(op_w), .zero(zero_w), .mem_ready(mr_w),
    .PCWrite(pcw_w), .AdrSrc(adr_w), .MemWrite(memw_w), .IRWrite(irw_w),
    .RegWrite(regw_w), .ResultSrc(rs_w), .ALUSrcA(sa_w), .ALUSrcB(sb_w),
    .ALUOp(aop_w), .ImmSrc(imm_w), .illegal(ill_w), .instret(cnt_w)
  );

  main_fsm #(.MEM_WAIT(0), .EN_LUI(0), .CNT_W(4)) dut_n (
    .clk(clk), .reset_n(rstn_n), .op(op_n), .zero(zero_n), .mem_ready(mr_n),
    .PCWrite(pcw_n), .AdrSrc(adr_n), .MemWrite(memw_n), .IRWrite(irw_n),
    .RegWrite(regw_n), .ResultSrc(rs_n), .ALUSrcA(sa_n), .ALUSrcB(sb_n),
    .ALUOp(aop_n), .ImmSrc(imm_n), .illegal(ill_n), .instret(cnt_n)
  );

  always #5 clk = ~clk;

  function automatic int classify(input logic [6:0] o, input bit en_lui);
    case (o)
      LW:      return C_LW;
      SW:      return C_SW;
      RT:      return C_R;
      IT:      return C_I;
      BEQ:     return C_BEQ;
      JAL:     return C_JAL;
      LUI:     return en_lui ? C_LUI : C_TRAP;
      default: return C_TRAP;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      SW:      return 3'b001;
      BEQ:     return 3'b010;
      JAL:     return 3'b011;
      LUI:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Control-signal table: one row per step.
  function automatic logic [16:0] expect_out(input int ph, input logic [6:0] o,
                                             input logic z, input logic go);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, aop;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
    case (ph)
      PH_F:   begin sb = 2'b10; rs = 2'b10; irw = go; pcw = go; end
      PH_D:   begin sa = 2'b01; sb = 2'b01; end
      PH_MA:  begin sa = 2'b10; sb = 2'b01; end
      PH_MR:  begin adr = 1; end
      PH_MWB: begin rs = 2'b01; rw = 1; end
      PH_MWR: begin adr = 1; mw = 1; end
      PH_ER:  begin sa = 2'b10; aop = 2'b10; end
      PH_EI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      PH_AW:  begin rw = 1; end
      PH_B:   begin sa = 2'b10; aop = 2'b01; pcw = z; end
      PH_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      PH_L:   begin sa = 2'b11; sb = 2'b01; end
      PH_T:   begin ill = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm_of(o), ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] ob, input logic [31:0] ex);
    n_cmp++;
    assert (ob === ex) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, ob, ex);
    end
  endtask

  // One clock of one step: drive at edge+1, check at negedge, move past next edge.
  task automatic cycle_chk(input bit sel, input int ph, input logic [6:0] o,
                           input logic z, input logic mr, input string tag);
    logic go;
    logic [16:0] ex, ob;
    logic [31:0] cnt_ob, cnt_ex;
    if (sel) begin op_n = o; zero_n = z; mr_n = mr; end
    else     begin op_w = o; zero_w = z; mr_w = mr; end
    @(negedge clk);
    go = sel ? 1'b1 : mr;
    ex = expect_out(ph, o, z, go);
    ob = sel ? obs_n : obs_w;
    check($sformatf("%s step%0d ctl", tag, ph), 32'(ob), 32'(ex));
    cnt_ob = sel ? 32'(cnt_n) : cnt_w;
    cnt_ex = sel ? (cnt_m_n % 16) : cnt_m_w;
    check($sformatf("%s step%0d instret", tag, ph), cnt_ob, cnt_ex);
    @(posedge clk);
    #1;
  endtask

  // Memory-type step with 'waits' stalled cycles (waits only matter on dut_w).
  task automatic mem_step(input bit sel, input int ph, input logic [6:0] o,
                          input int waits, input string tag);
    if (!sel)
      for (int i = 0; i < waits; i++) cycle_chk(sel, ph, o, 1'($urandom), 1'b0, tag);
    cycle_chk(sel, ph, o, 1'($urandom), sel ? 1'($urandom) : 1'b1, tag);
  endtask

  task automatic run_instr(input bit sel, input logic [6:0] o, input logic z,
                           input int fw, input int mw, input string tag,
                           output bit trapped);
    int c;
    c = classify(o, !sel);
    trapped = 0;
    mem_step(sel, PH_F, o, fw, tag);
    cycle_chk(sel, PH_D, o, 1'($urandom), 1'($urandom), tag);
    case (c)
      C_LW: begin
        cycle_chk(sel, PH_MA, o, 1'($urandom), 1'($urandom), tag);
        mem_step(sel, PH_MR, o, mw, tag);
        cycle_chk(sel, PH_MWB, o, 1'($urandom), 1'($urandom), tag);
      end
      C_SW: begin
        cycle_chk(sel, PH_MA, o, 1'($urandom), 1'($urandom), tag);
        mem_step(sel, PH_MWR, o, mw, tag);
      end
      C_R:   begin cycle_chk(sel, PH_ER, o, 1'($urandom), 1'($urandom), tag);
                   cycle_chk(sel, PH_AW, o, 1'($urandom), 1'($urandom), tag); end
      C_I:   begin cycle_chk(sel, PH_EI, o, 1'($urandom), 1'($urandom), tag);
                   cycle_chk(sel, PH_AW, o, 1'($urandom), 1'($urandom), tag); end
      C_BEQ:       cycle_chk(sel, PH_B, o, z, 1'($urandom), tag);
      C_JAL: begin cycle_chk(sel, PH_J, o, 1'($urandom), 1'($urandom), tag);
                   cycle_chk(sel, PH_AW, o, 1'($urandom), 1'($urandom), tag); end
      C_LUI: begin cycle_chk(sel, PH_L, o, 1'($urandom), 1'($urandom), tag);
                   cycle_chk(sel, PH_AW, o, 1'($urandom), 1'($urandom), tag); end
      default: trapped = 1;
    endcase
    if (!trapped) begin
      if (sel) cnt_m_n++;
      else     cnt_m_w++;
    end
  endtask

  task automatic trap_hold(input bit sel, input int n, input string tag);
    for (int i = 0; i < n; i++)
      cycle_chk(sel, PH_T, 7'($urandom), 1'($urandom), 1'($urandom), tag);
  endtask

  // Reset takes effect before the next edge: check FETCH, counter and flag.
  task automatic check_reset(input bit sel, input string tag);
    logic [16:0] ex, ob;
    logic [31:0] cnt_ob;
    ex = expect_out(PH_F, sel ? op_n : op_w, 1'b0, 1'b0) & RST_MASK;
    ob = (sel ? obs_n : obs_w) & RST_MASK;
    check($sformatf("%s rst ctl", tag), 32'(ob), 32'(ex));
    cnt_ob = sel ? 32'(cnt_n) : cnt_w;
    check($sformatf("%s rst instret", tag), cnt_ob, 32'd0);
  endtask

  task automatic do_reset(input bit sel, input string tag);
    if (sel) rstn_n = 1'b0;
    else     rstn_w = 1'b0;
    #1;
    check_reset(sel, tag);
    if (sel) cnt_m_n = 0;
    else     cnt_m_w = 0;
    @(posedge clk);
    #1;
    if (sel) rstn_n = 1'b1;
    else     rstn_w = 1'b1;
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] tbl [8];
    tbl = '{LW, SW, RT, IT, BEQ, JAL, LUI, 7'h00};
    tbl[7] = 7'($urandom);
    return tbl[$urandom_range(0, 7)];
  endfunction

  initial begin
    bit tr;
    clk = 1'b0;
    rstn_w = 1'b0; rstn_n = 1'b0;
    op_w = 7'h0; op_n = 7'h0; zero_w = 0; zero_n = 0; mr_w = 0; mr_n = 0;
    #2;
    check_reset(0, "init_w");
    check_reset(1, "init_n");
    @(posedge clk); #1;
    rstn_w = 1'b1;

    // ---- dut_w: MEM_WAIT=1, EN_LUI=1 ----
    run_instr(0, LW, 0, 0, 0, "w_lw", tr);
    run_instr(0, SW, 0, 1, 3, "w_sw_wait3", tr);
    run_instr(0, BEQ, 1, 0, 0, "w_beq_taken", tr);
    run_instr(0, BEQ, 0, 0, 0, "w_beq_not", tr);
    run_instr(0, RT, 0, 2, 0, "w_rtype", tr);
    run_instr(0, IT, 0, 0, 0, "w_itype", tr);
    run_instr(0, JAL, 0, 0, 0, "w_jal", tr);
    run_instr(0, LUI, 0, 0, 0, "w_lui", tr);
    run_instr(0, LW, 0, 0, 2, "w_lw_wait2", tr);

    // Reset during a MEMREAD wait
    cycle_chk(0, PH_F, LW, 0, 1'b1, "w_abort");
    cycle_chk(0, PH_D, LW, 0, 1'b0, "w_abort");
    cycle_chk(0, PH_MA, LW, 0, 1'b0, "w_abort");
    cycle_chk(0, PH_MR, LW, 0, 1'b0, "w_abort");
    do_reset(0, "w_abort");
    run_instr(0, RT, 0, 0, 0, "w_after_rst", tr);

    // Illegal opcode: absorbing trap, counter frozen
    run_instr(0, 7'h7F, 0, 0, 0, "w_ill", tr);
    check("w_ill trapped", 32'(tr), 32'd1);
    trap_hold(0, 20, "w_trap");
    do_reset(0, "w_trap");

    for (int k = 0; k < 60; k++) begin
      run_instr(0, rand_op(), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 3), "w_rand", tr);
      if (tr) begin
        trap_hold(0, $urandom_range(1, 4), "w_rand_trap");
        do_reset(0, "w_rand_trap");
      end
    end
    rstn_w = 1'b0;

    // ---- dut_n: MEM_WAIT=0, EN_LUI=0, CNT_W=4 ----
    rstn_n = 1'b1;
    run_instr(1, LW, 0, 0, 0, "n_lw", tr);
    run_instr(1, SW, 0, 0, 0, "n_sw", tr);
    run_instr(1, LUI, 0, 0, 0, "n_lui", tr);
    check("n_lui trapped", 32'(tr), 32'd1);
    trap_hold(1, 5, "n_trap");
    do_reset(1, "n_trap");

    for (int k = 0; k < 17; k++) run_instr(1, RT, 0, 0, 0, "n_wrap", tr);
    // Counter should now read 17 mod 16 = 1; reset lands in EXECR.
    cycle_chk(1, PH_F, RT, 0, 1'b0, "n_wrap_last");
    cycle_chk(1, PH_D, RT, 0, 1'b0, "n_wrap_last");
    do_reset(1, "n_execr");
    run_instr(1, BEQ, 1, 0, 0, "n_after_rst", tr);

    for (int k = 0; k < 40; k++) begin
      run_instr(1, rand_op(), 1'($urandom), 0, 0, "n_rand", tr);
      if (tr) begin
        trap_hold(1, $urandom_range(1, 4), "n_rand_trap");
        do_reset(1, "n_rand_trap");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
